encoder_8x3_seq: RTL
====================

// Module: encoder_8x3_seq
// PURPOSE
//  Sequential 8-to-3 encoder; the inverse of the team's Decoder_3x8 (a,b,c -> d[7:0]).
//  - Captures an 8-bit request vector d with a valid/ready handshake.
//  - Emits the 3-bit index {a,b,c} of every set bit, one per accepted output beat.
//  - Order is highest bit first; a is the index MSB, c the LSB.
//  - Sits between request/interrupt sources and consumers of a binary index.
// PARAMETERS
//  HIGH_FIRST  1  1: serve the highest set bit first; 0: serve the lowest set bit first.
// PORTS
//  clk        in   1  Single clock; rising edge.
//  rst_n      in   1  Asynchronous, active-low reset.
//  d          in   8  Request vector; bit i set requests index i.
//  in_valid   in   1  d is valid this cycle.
//  in_ready   out  1  Block can accept a vector (combinational from state).
//  a          out  1  Index bit 2 (MSB), registered.
//  b          out  1  Index bit 1, registered.
//  c          out  1  Index bit 0 (LSB), registered.
//  out_valid  out  1  {a,b,c} is valid.
//  out_ready  in   1  Consumer accepts the index this cycle.
//  out_last   out  1  The current index is the final set bit of the captured vector.
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state=IDLE; pend=8'h00.
//    a=b=c=0, out_valid=0, out_last=0; in_ready=1 once reset is released.
//  - State IDLE: in_ready=1 and out_valid=0.
//    - On in_valid=1 with d!=0 at edge k: pend<=d, go to SCAN.
//      Load {a,b,c} and out_last from d, so out_valid=1 at cycle k+1.
//    - On in_valid=1 with d==0: the vector is dropped and the block stays in IDLE.
//      Exception: see CONFIGURATION.
//  - State SCAN: in_ready=0; out_valid=1; {a,b,c} is the selected index of pend.
//    out_last=1 when pend has exactly one bit set.
//  - Output handshake: a beat transfers when out_valid=1 and out_ready=1.
//    - On a transfer, clear the served bit in pend.
//    - If bits remain, load the next index into {a,b,c} at the same edge.
//    - If no bits remain, go to IDLE and drop out_valid to 0.
//  - While out_ready=0, {a,b,c}, out_last and pend hold; outputs must not change while stalled.
//  - Throughput: 1 index per cycle while out_ready=1.
//    Next-vector acceptance needs one IDLE cycle after the last beat.
//  - in_valid asserted during SCAN is ignored. The source must hold d and in_valid until in_ready=1.
//  - a,b,c keep their last value in IDLE; they are don't-care when out_valid=0.
//  - rst_n asserted mid-SCAN: abort immediately and return to reset values.
//    The partially served vector is discarded.
//  - 8'hFF yields 8 beats: 7..0 (HIGH_FIRST=1) or 0..7 (HIGH_FIRST=0); out_last=1 only on the 8th.
// CONFIGURATION
//  - ENC_ZERO_FLAG_EN defined:
//    - Adds output port zero (1 bit, registered, reset 0).
//    - A captured d==0 produces one beat: {a,b,c}=3'b000, zero=1, out_last=1.
//    - zero=0 on every other beat.
//  - ENC_ZERO_FLAG_EN undefined: the zero port is absent; d==0 is silently dropped.
// TESTING
//  - Reset: rst_n=0 mid-run -> a=b=c=0, out_valid=0; in_ready=1 after release.
//  - d=8'b0000_1000, out_ready=1 -> one beat {a,b,c}=3'b011, out_last=1, one cycle after capture.
//  - d=8'b1001_0001, HIGH_FIRST=1, out_ready=1 -> beats 7,4,0 on consecutive cycles.
//    out_last=1 on index 0 only.
//  - d=8'b0110_0000, out_ready low for 3 cycles -> {a,b,c}=3'b110 held stable.
//    out_ready then high -> 3'b101 with out_last=1, then IDLE.
//  - d=8'hFF with in_valid held during SCAN -> in_ready=0 for all 8 beats.
//    A second vector 8'h01 is accepted only after the IDLE cycle -> index 0.
//  - d=8'h00 -> no beat (macro off).
//    With ENC_ZERO_FLAG_EN: one beat with zero=1, {a,b,c}=0, out_last=1.

Source files
------------

// File: rtl/encoder_8x3_seq_if.sv
// Handshake bundle for encoder_8x3_seq: request vector in, binary index beats out.
// The zero port exists only when ENC_ZERO_FLAG_EN is defined.
interface encoder_8x3_seq_if;
  logic [7:0] d;
  logic       in_valid;
  logic       in_ready;
  logic       a;
  logic       b;
  logic       c;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
`ifdef ENC_ZERO_FLAG_EN
  logic       zero;

  modport master (
    output d, in_valid, out_ready,
    input  in_ready, a, b, c, out_valid, out_last, zero
  );

  modport slave (
    input  d, in_valid, out_ready,
    output in_ready, a, b, c, out_valid, out_last, zero
  );
`else
  modport master (
    output d, in_valid, out_ready,
    input  in_ready, a, b, c, out_valid, out_last
  );

  modport slave (
    input  d, in_valid, out_ready,
    output in_ready, a, b, c, out_valid, out_last
  );
`endif
endinterface

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index of every set bit.
// Optional macro ENC_ZERO_FLAG_EN turns a captured all-zero vector into a single flagged beat.
module encoder_8x3_seq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  encoder_8x3_seq_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_pend, w_pend_d;
  logic [2:0] r_idx, w_idx_d;
  logic       r_last, w_last_d;
  logic [7:0] w_pend_left;

  // Index of the set bit that is served next (highest or lowest depending on HIGH_FIRST).
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  assign w_pend_left = r_pend & ~(8'd1 << r_idx);

`ifdef ENC_ZERO_FLAG_EN
  logic r_zero, w_zero_d;
`endif

  always_comb begin
    w_state_d = r_state;
    w_pend_d  = r_pend;
    w_idx_d   = r_idx;
    w_last_d  = r_last;
`ifdef ENC_ZERO_FLAG_EN
    w_zero_d  = r_zero;
`endif
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.d != 8'd0) begin
            w_pend_d  = bus.d;
            w_idx_d   = pick(bus.d);
            w_last_d  = single_bit(bus.d);
            w_state_d = StScan;
`ifdef ENC_ZERO_FLAG_EN
            w_zero_d  = 1'b0;
          end else begin
            // pend stays empty so the single flagged beat retires like a last bit
            w_pend_d  = 8'd0;
            w_idx_d   = 3'd0;
            w_last_d  = 1'b1;
            w_zero_d  = 1'b1;
            w_state_d = StScan;
`endif
          end
        end
      end
      StScan: begin
        if (bus.out_ready) begin
          w_pend_d = w_pend_left;
`ifdef ENC_ZERO_FLAG_EN
          w_zero_d = 1'b0;
`endif
          if (w_pend_left != 8'd0) begin
            w_idx_d  = pick(w_pend_left);
            w_last_d = single_bit(w_pend_left);
          end else begin
            // index bits keep their last value in IDLE
            w_last_d  = 1'b0;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pend  <= 8'd0;
      r_idx   <= 3'd0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pend  <= w_pend_d;
      r_idx   <= w_idx_d;
      r_last  <= w_last_d;
    end
  end

`ifdef ENC_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else begin
      r_zero <= w_zero_d;
    end
  end

  assign bus.zero = r_zero;
`endif

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StScan);
  assign bus.a         = r_idx[2];
  assign bus.b         = r_idx[1];
  assign bus.c         = r_idx[0];
  assign bus.out_last  = r_last;

endmodule
